// File: rtl/discrete_pkg.sv
// Shared types, constants and helpers for the discrete audio chain.
//   sample_t      : 16-bit unsigned audio sample
//   gain_q8_8_t   : 16-bit unsigned Q8.8 gain (GAIN_UNITY = 1.0)
//   mix_state_e   : mixer sequencing states
//   saturate_u16  : drop 8 fractional bits of a wide accumulator, clamp to 16 bits
package discrete_pkg;

  typedef logic [15:0] sample_t;
  typedef logic [15:0] gain_q8_8_t;

  localparam gain_q8_8_t GAIN_UNITY = 16'd256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SAT   = 2'd2,
    ST_OUT   = 2'd3
  } mix_state_e;

  // Only the low 'width' bits of acc are meaningful; the rest are masked off.
  function automatic sample_t saturate_u16(input logic [63:0] acc, input int unsigned width);
    logic [63:0] mask;
    logic [63:0] shifted;
    mask    = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    shifted = (acc & mask) >> 8;
    return (shifted > 64'd65535) ? 16'hFFFF : shifted[15:0];
  endfunction

endpackage

// File: rtl/discrete_audio_mixer_if.sv
// Sample-side bus of the audio mixer.
//   audio_clk_en : one-cycle sample strobe (master -> mixer)
//   in           : packed channel samples, channel i at [16*i+15:16*i]
//   out          : mixed sample (mixer -> master)
//   out_valid    : one-cycle pulse when out updates
//   busy         : a mix is in progress
interface discrete_audio_mixer_if
  import discrete_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 4
);

  logic                        audio_clk_en;
  logic [16*NUM_INPUTS-1:0]    in;
  sample_t                     out;
  logic                        out_valid;
  logic                        busy;

  modport master (
    output audio_clk_en,
    output in,
    input  out,
    input  out_valid,
    input  busy
  );

  modport slave (
    input  audio_clk_en,
    input  in,
    output out,
    output out_valid,
    output busy
  );

endinterface

// File: rtl/discrete_mac_unit.sv
// Registered unsigned multiply-accumulate with synchronous clear and enable.
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the accumulator (has priority over en)
//   en         : acc += a * b
//   a, b       : unsigned operands
//   acc        : registered accumulator
module discrete_mac_unit #(
  parameter int unsigned A_W   = 16,
  parameter int unsigned B_W   = 16,
  parameter int unsigned ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic [ACC_W-1:0] acc
);

  localparam int unsigned P_W = A_W + B_W;

  logic [P_W-1:0] prod_c;

  assign prod_c = P_W'(a) * P_W'(b);

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod_c);
    end
  end

endmodule

// File: rtl/discrete_audio_mixer.sv
// Time-multiplexed weighted summer: captures all channels on the sample
// strobe, walks them one per clock through a shared MAC, then saturates
// and presents one 16-bit sample per audio tick.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : audio_clk_en, in -> out, out_valid, busy
//   clip_count   : saturation event counter (only with DISCRETE_MIXER_CLIP_COUNT_EN)
// Optional feature macro: DISCRETE_MIXER_CLIP_COUNT_EN
module discrete_audio_mixer
  import discrete_pkg::*;
#(
  parameter int unsigned              NUM_INPUTS      = 4,
  parameter logic [16*NUM_INPUTS-1:0] GAINS_8_SHIFTED = {NUM_INPUTS{16'd64}},
  parameter int unsigned              CLOCK_RATE      = 50000000,
  parameter int unsigned              SAMPLE_RATE     = 48000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  discrete_audio_mixer_if.slave     bus
`ifdef DISCRETE_MIXER_CLIP_COUNT_EN
  ,
  output logic [15:0]               clip_count
`endif
);

  localparam int unsigned IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int unsigned ACC_W = 32 + $clog2(NUM_INPUTS) + 1;

  // Elaboration-time sanity checks
  if (NUM_INPUTS < 1 || NUM_INPUTS > 16) begin : g_num_check
    $error("discrete_audio_mixer: NUM_INPUTS must be 1..16");
  end
  if (CLOCK_RATE / SAMPLE_RATE < NUM_INPUTS + 3) begin : g_rate_check
    $error("discrete_audio_mixer: clock too slow to mix all channels per sample");
  end

  mix_state_e       state_q;
  logic [IDX_W-1:0] idx_q;
  sample_t          cap_q [NUM_INPUTS];
  gain_q8_8_t       gain_c [NUM_INPUTS];
  sample_t          out_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [ACC_W-1:0] mac_acc;
  logic             mac_clr_c;
  logic             mac_en_c;
  sample_t          sat_c;
  logic             clip_c;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_gain
    assign gain_c[g] = GAINS_8_SHIFTED[16*g +: 16];
  end

  assign mac_clr_c = (state_q == ST_IDLE) && bus.audio_clk_en;
  assign mac_en_c  = (state_q == ST_ACCUM);

  discrete_mac_unit #(
    .A_W   (16),
    .B_W   (16),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (mac_clr_c),
    .en    (mac_en_c),
    .a     (cap_q[idx_q]),
    .b     (gain_c[idx_q]),
    .acc   (mac_acc)
  );

  // Anything at or above bit 24 means (acc >> 8) exceeds 16 bits
  assign sat_c  = saturate_u16(64'(mac_acc), ACC_W);
  assign clip_c = |mac_acc[ACC_W-1:24];

  // Sequencer, capture register and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        cap_q[i] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.audio_clk_en) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
              cap_q[i] <= bus.in[16*i +: 16];
            end
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (idx_q == IDX_W'(NUM_INPUTS - 1)) begin
            state_q <= ST_SAT;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_SAT: begin
          // out_valid/busy take effect in the OUT cycle
          out_q       <= sat_c;
          out_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= ST_OUT;
        end
        ST_OUT: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DISCRETE_MIXER_CLIP_COUNT_EN
  // Saturation event counter; sticks at all-ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clip_count <= '0;
    end else if (state_q == ST_SAT && clip_c && clip_count != 16'hFFFF) begin
      clip_count <= clip_count + 16'd1;
    end
  end
`endif

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_discrete_audio_mixer.sv
// Bench for discrete_audio_mixer: three instances (4ch unity, 4ch mixed gains,
// 1ch max gain) checked every cycle against a timing/arith model.
module tb_discrete_audio_mixer;
  import discrete_pkg::*;

  localparam logic [63:0] G_U = {4{GAIN_UNITY}};
  localparam logic [63:0] G_G = {16'd0, 16'd512, 16'd256, 16'd128};
  localparam logic [15:0] G_1 = 16'hFFFF;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  discrete_audio_mixer_if #(.NUM_INPUTS(4)) ifu ();
  discrete_audio_mixer_if #(.NUM_INPUTS(4)) ifg ();
  discrete_audio_mixer_if #(.NUM_INPUTS(1)) if1 ();

`ifdef DISCRETE_MIXER_CLIP_COUNT_EN
  logic [15:0] clip_u, clip_g, clip_1;
`endif

  discrete_audio_mixer #(.NUM_INPUTS(4), .GAINS_8_SHIFTED(G_U), .CLOCK_RATE(50000000), .SAMPLE_RATE(48000))
  dut_u (.clk(clk), .reset_n(reset_n), .bus(ifu)
`ifdef DISCRETE_MIXER_CLIP_COUNT_EN
    , .clip_count(clip_u)
`endif
  );

  discrete_audio_mixer #(.NUM_INPUTS(4), .GAINS_8_SHIFTED(G_G), .CLOCK_RATE(50000000), .SAMPLE_RATE(48000))
  dut_g (.clk(clk), .reset_n(reset_n), .bus(ifg)
`ifdef DISCRETE_MIXER_CLIP_COUNT_EN
    , .clip_count(clip_g)
`endif
  );

  discrete_audio_mixer #(.NUM_INPUTS(1), .GAINS_8_SHIFTED(G_1), .CLOCK_RATE(50000000), .SAMPLE_RATE(48000))
  dut_1 (.clk(clk), .reset_n(reset_n), .bus(if1)
`ifdef DISCRETE_MIXER_CLIP_COUNT_EN
    , .clip_count(clip_1)
`endif
  );

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference mix: {clipped, value}
  function automatic logic [16:0] ref_mix(input logic [63:0] smp, input logic [63:0] g, input int n);
    longint unsigned acc;
    longint unsigned sh;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      acc += longint'(smp[16*i +: 16]) * longint'(g[16*i +: 16]);
    end
    sh = acc >> 8;
    return (sh > 65535) ? 17'h1FFFF : {1'b0, sh[15:0]};
  endfunction

  // ---------------- model: one mix at a time, fixed latency ----------------
  int          n_of   [3] = '{4, 4, 1};
  logic [63:0] g_of   [3] = '{G_U, G_G, 64'(G_1)};
  bit          m_act  [3];
  longint      m_start[3];
  logic [16:0] m_pend [3];
  logic [15:0] m_out  [3];
  logic [15:0] m_clip [3];
  logic        en_a   [3];
  logic [63:0] in_a   [3];

  always @(posedge clk) begin
    cyc++;
    en_a[0] = ifu.audio_clk_en; en_a[1] = ifg.audio_clk_en; en_a[2] = if1.audio_clk_en;
    in_a[0] = ifu.in; in_a[1] = ifg.in; in_a[2] = 64'(if1.in);
    for (int m = 0; m < 3; m++) begin
      if (!reset_n) begin
        m_act[m] = 1'b0; m_out[m] = '0; m_clip[m] = '0;
      end else begin
        if (m_act[m] && cyc == m_start[m] + n_of[m] + 1) begin
          m_out[m] = m_pend[m][15:0];
          if (m_pend[m][16] && m_clip[m] != 16'hFFFF) m_clip[m]++;
        end
        if (en_a[m] && (!m_act[m] || cyc >= m_start[m] + n_of[m] + 3)) begin
          m_act[m]   = 1'b1;
          m_start[m] = cyc;
          m_pend[m]  = ref_mix(in_a[m], g_of[m], n_of[m]);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [15:0] o_a [3];
  logic        v_a [3];
  logic        b_a [3];

  always @(negedge clk) begin
    o_a[0] = ifu.out; o_a[1] = ifg.out; o_a[2] = if1.out;
    v_a[0] = ifu.out_valid; v_a[1] = ifg.out_valid; v_a[2] = if1.out_valid;
    b_a[0] = ifu.busy; b_a[1] = ifg.busy; b_a[2] = if1.busy;
    for (int m = 0; m < 3; m++) begin
      bit bexp, vexp;
      bexp = reset_n && m_act[m] && cyc >= m_start[m] && cyc <= m_start[m] + n_of[m];
      vexp = reset_n && m_act[m] && cyc == m_start[m] + n_of[m] + 1;
      chk($sformatf("out[%0d]@%0d", m, cyc), o_a[m], reset_n ? m_out[m] : 16'd0);
      chk($sformatf("out_valid[%0d]@%0d", m, cyc), v_a[m], vexp);
      chk($sformatf("busy[%0d]@%0d", m, cyc), b_a[m], bexp);
    end
`ifdef DISCRETE_MIXER_CLIP_COUNT_EN
    chk($sformatf("clip_count[0]@%0d", cyc), clip_u, reset_n ? m_clip[0] : 16'd0);
    chk($sformatf("clip_count[1]@%0d", cyc), clip_g, reset_n ? m_clip[1] : 16'd0);
    chk($sformatf("clip_count[2]@%0d", cyc), clip_1, reset_n ? m_clip[2] : 16'd0);
`endif
  end

  // ---------------- stimulus helpers ----------------
  longint strobe_cyc;

  task automatic strobe(input logic [63:0] vu, input logic [63:0] vg, input logic [15:0] v1);
    @(negedge clk); #1;
    ifu.in = vu; ifg.in = vg; if1.in = v1;
    ifu.audio_clk_en = 1'b1; ifg.audio_clk_en = 1'b1; if1.audio_clk_en = 1'b1;
    strobe_cyc = cyc;
    @(negedge clk); #1;
    ifu.audio_clk_en = 1'b0; ifg.audio_clk_en = 1'b0; if1.audio_clk_en = 1'b0;
  endtask

  // Bounded wait recording the first out_valid cycle of each instance
  task automatic wait_done(output longint tu, output longint tg, output longint t1);
    tu = -1; tg = -1; t1 = -1;
    repeat (20) begin
      @(negedge clk);
      if (ifu.out_valid && tu < 0) tu = cyc;
      if (ifg.out_valid && tg < 0) tg = cyc;
      if (if1.out_valid && t1 < 0) t1 = cyc;
    end
    #1;
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 3))
      0:       return 16'hFFFF;
      1:       return 16'($urandom_range(0, 255));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint tu, tg, t1;
    int nv;
    logic [15:0] vval;
    ifu.audio_clk_en = 0; ifg.audio_clk_en = 0; if1.audio_clk_en = 0;
    ifu.in = '0; ifg.in = '0; if1.in = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;

    // model pins
    chk("model_unity", ref_mix({16'd4000, 16'd3000, 16'd2000, 16'd1000}, G_U, 4), 10000);
    chk("model_gains", ref_mix({4{16'd1000}}, G_G, 4), 3500);
    chk("model_n1", ref_mix(64'hFFFF, 64'hFFFF, 1), 17'h1FFFF);
    chk("reset_out", ifu.out, 0);
    chk("reset_busy", ifu.busy, 0);

    // basic mix, latency, mixed gains, single channel max
    strobe({16'd4000, 16'd3000, 16'd2000, 16'd1000}, {4{16'd1000}}, 16'hFFFF);
    wait_done(tu, tg, t1);
    chk("lat_unity", tu - strobe_cyc, 6);
    chk("lat_gains", tg - strobe_cyc, 6);
    chk("lat_n1", t1 - strobe_cyc, 3);
    chk("out_unity", ifu.out, 10000);
    chk("out_gains", ifg.out, 3500);
    chk("out_n1", if1.out, 16'hFFFF);
`ifdef DISCRETE_MIXER_CLIP_COUNT_EN
    chk("clip_u_0", clip_u, 0);
`endif

    // saturation
    strobe({4{16'd30000}}, {4{16'd30000}}, 16'd1);
    wait_done(tu, tg, t1);
    chk("out_clip1", ifu.out, 16'hFFFF);
`ifdef DISCRETE_MIXER_CLIP_COUNT_EN
    chk("clip_u_1", clip_u, 1);
`endif
    strobe({4{16'd30000}}, {4{16'd30000}}, 16'd1);
    wait_done(tu, tg, t1);
    chk("out_clip2", ifu.out, 16'hFFFF);
`ifdef DISCRETE_MIXER_CLIP_COUNT_EN
    chk("clip_u_2", clip_u, 2);
`endif

    // strobe while busy is ignored
    strobe({16'd4000, 16'd3000, 16'd2000, 16'd1000}, 64'd0, 16'd0);
    strobe(64'd0, 64'd0, 16'd0);
    nv = 0; vval = '0;
    repeat (12) begin
      @(negedge clk);
      if (ifu.out_valid) begin nv++; vval = ifu.out; end
    end
    chk("busy_strobe_valids", nv, 1);
    chk("busy_strobe_value", vval, 10000);
    strobe(64'd0, 64'd0, 16'd0);
    wait_done(tu, tg, t1);
    chk("zero_mix", ifu.out, 0);

    // reset during ACCUM
    strobe({4{16'd7000}}, {4{16'd7000}}, 16'd7000);
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_out", ifu.out, 0);
    chk("rst_mid_busy", ifu.busy, 0);
    nv = 0;
    repeat (2) begin @(negedge clk); if (ifu.out_valid) nv++; end
    #1 reset_n = 1'b1;
    repeat (8) begin @(negedge clk); if (ifu.out_valid) nv++; end
    chk("rst_no_valid", nv, 0);
    strobe({4{16'd1}}, {4{16'd1}}, 16'd1);
    wait_done(tu, tg, t1);
    chk("post_rst_mix", ifu.out, 4);

    // randomized traffic
    repeat (400) begin
      @(negedge clk); #1;
      ifu.in = {rnd16(), rnd16(), rnd16(), rnd16()};
      ifg.in = {rnd16(), rnd16(), rnd16(), rnd16()};
      if1.in = rnd16();
      ifu.audio_clk_en = ($urandom_range(0, 3) == 0);
      ifg.audio_clk_en = ($urandom_range(0, 3) == 0);
      if1.audio_clk_en = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk); #1;
    ifu.audio_clk_en = 0; ifg.audio_clk_en = 0; if1.audio_clk_en = 0;
    repeat (12) @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
